uart_cmd_seq: RTL

UART_CMD_SEQ -- requirements
Module: uart_cmd_seq

---
 rtl/uart_cmd_seq.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles framed UART bytes into a command with a
// valid/ready handshake, a per-byte inactivity timeout and overrun reporting.
// Frame: SYNC_BYTE, cmd, addr, data_hi, data_lo [, checksum].
// Optional feature macro: UART_CMD_CHKSUM_EN adds the trailing checksum byte
// (8-bit sum of cmd..checksum must be zero).
module uart_cmd_seq #(
    parameter logic [7:0]  SYNC_BYTE = 8'hAA,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    input  logic        cmd_rdy,
    output logic        cmd_vld,
    output logic [7:0]  cmd,
    output logic [7:0]  addr,
    output logic [15:0] wdata,
    output logic        busy,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_DHI,
        S_DLO,
`ifdef UART_CMD_CHKSUM_EN
        S_CHK,
`endif
        S_ISSUE
    } state_t;

    localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
`ifdef UART_CMD_CHKSUM_EN
    localparam logic [1:0] ERR_CHECKSUM = 2'b10;
`endif
    localparam logic [1:0] ERR_OVERRUN  = 2'b11;

    state_t      state_q, state_d;
    logic        rx_rdy_q, rx_rdy_d;
    logic [15:0] tmo_cnt_q, tmo_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [7:0]  addr_q, addr_d;
    logic [7:0]  dhi_q, dhi_d;
    logic [7:0]  dlo_q, dlo_d;
    logic        err_q, err_d;
    logic [1:0]  err_code_q, err_code_d;

    logic        bev;
    logic        in_frame;
    logic        tmo_hit;
    logic        chk_bad;
    logic        ovr;

    assign bev      = rx_rdy & ~rx_rdy_q;
    assign in_frame = (state_q != S_IDLE) && (state_q != S_ISSUE);
    // A byte event in the expiry cycle takes priority over the timeout.
    assign tmo_hit  = in_frame && !bev && (tmo_cnt_q == TIMEOUT - 16'd1);
    assign ovr      = (state_q == S_ISSUE) && bev;

`ifdef UART_CMD_CHKSUM_EN
    logic [7:0] chk_sum;
    assign chk_sum = cmd_q + addr_q + dhi_q + dlo_q + rx_data;
    assign chk_bad = (state_q == S_CHK) && bev && (chk_sum != 8'h00);
`else
    assign chk_bad = 1'b0;
`endif

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rx_rdy_q   <= 1'b0;
            tmo_cnt_q  <= '0;
            cmd_q      <= '0;
            addr_q     <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            rx_rdy_q   <= rx_rdy_d;
            tmo_cnt_q  <= tmo_cnt_d;
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            dhi_q      <= dhi_d;
            dlo_q      <= dlo_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Next-state logic: advance one field per byte event
    always_comb begin
        state_d = state_q;
        if (tmo_hit) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: if (bev && rx_data == SYNC_BYTE) state_d = S_CMD;
                S_CMD:  if (bev) state_d = S_ADDR;
                S_ADDR: if (bev) state_d = S_DHI;
                S_DHI:  if (bev) state_d = S_DLO;
`ifdef UART_CMD_CHKSUM_EN
                S_DLO:  if (bev) state_d = S_CHK;
                S_CHK:  if (bev) state_d = chk_bad ? S_IDLE : S_ISSUE;
`else
                S_DLO:  if (bev) state_d = S_ISSUE;
`endif
                S_ISSUE: if (cmd_rdy) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Field capture, timeout counter and error reporting
    always_comb begin
        rx_rdy_d   = rx_rdy;
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        dhi_d      = dhi_q;
        dlo_d      = dlo_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        tmo_cnt_d  = '0;

        if (in_frame && !bev && !tmo_hit) begin
            tmo_cnt_d = tmo_cnt_q + 16'd1;
        end

        if (bev) begin
            case (state_q)
                S_CMD:  cmd_d  = rx_data;
                S_ADDR: addr_d = rx_data;
                S_DHI:  dhi_d  = rx_data;
                S_DLO:  dlo_d  = rx_data;
                default: ;
            endcase
        end

        if (tmo_hit) begin
            err_d      = 1'b1;
            err_code_d = ERR_TIMEOUT;
        end
`ifdef UART_CMD_CHKSUM_EN
        if (chk_bad) begin
            err_d      = 1'b1;
            err_code_d = ERR_CHECKSUM;
        end
`endif
        if (ovr) begin
            err_d      = 1'b1;
            err_code_d = ERR_OVERRUN;
        end
    end

    // Output decode from registered state
    always_comb begin
        cmd_vld  = (state_q == S_ISSUE);
        busy     = (state_q != S_IDLE);
        cmd      = cmd_q;
        addr     = addr_q;
        wdata    = {dhi_q, dlo_q};
        err      = err_q;
        err_code = err_code_q;
    end

endmodule
